// File: rtl/wb_port_pkg.sv
// Shared definitions for the user-port Wishbone responder: register offsets,
// CTRL/STATUS bit positions, FIFO geometry and a byte-enable merge helper.
package wb_port_pkg;

   localparam logic [7:0] OFS_OUT    = 8'h00;
   localparam logic [7:0] OFS_CNT    = 8'h04;
   localparam logic [7:0] OFS_CTRL   = 8'h08;
   localparam logic [7:0] OFS_FIFO   = 8'h0C;
   localparam logic [7:0] OFS_STATUS = 8'h10;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_CLR_BIT = 1;

   localparam int ST_EMPTY_BIT = 8;
   localparam int ST_FULL_BIT  = 9;
   localparam int ST_OVF_BIT   = 10;

   localparam int FIFO_W  = 8;
   // Level is wide enough for the largest allowed depth (64 entries).
   localparam int LEVEL_W = 7;

   // Replace each byte of old_val by the matching byte of new_val where sel is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] result;
      result = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            result[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            result[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/wb_port_fifo.sv
// Small synchronous byte FIFO behind the FIFO register window. Pushes into a
// full FIFO and pops from an empty one are ignored; clr empties it at once.
module wb_port_fifo
   import wb_port_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic               clr,
   input  logic [FIFO_W-1:0]  din,
   output logic [FIFO_W-1:0]  dout,
   output logic [LEVEL_W-1:0] level,
   output logic               empty,
   output logic               full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [FIFO_W-1:0]  mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [LEVEL_W-1:0] count;
   logic               do_push;
   logic               do_pop;

   // Qualify requests against the current fill state.
   always_comb begin
      empty   = (count == {LEVEL_W{1'b0}});
      full    = (count == LEVEL_W'(DEPTH));
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      level   = count;
      dout    = mem[rd_ptr];
   end

   // Pointer and fill-count bookkeeping; clear has priority over traffic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {LEVEL_W{1'b0}};
      end else if (clr) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {LEVEL_W{1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + LEVEL_W'(1);
            2'b01:   count <= count - LEVEL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push & ~clr) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/wb_port_responder.sv
// Wishbone classic-cycle responder on the user project port: OUT register on
// the project I/Os, loadable free-running counter, control, FIFO window, status.
module wb_port_responder
   import wb_port_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [15:0] user_out,
   output logic [15:0] user_oeb
);

   logic [7:0]         ofs;
   logic               hit;
   logic               accept;
   logic               wr;
   logic               rd;
   logic               wr_out;
   logic               wr_cnt;
   logic               wr_ctrl;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_clr;
   logic               ovf_clr;
   logic [15:0]        out_next;
   logic [31:0]        cnt_next;
   logic [31:0]        rd_mux;
   logic [31:0]        status;
   logic [FIFO_W-1:0]  fifo_dout;
   logic [LEVEL_W-1:0] fifo_level;
   logic               fifo_empty;
   logic               fifo_full;

   logic               ack;
   logic [31:0]        dat;
   logic [15:0]        out_reg;
   logic [31:0]        cnt;
   logic               ctrl_en;
   logic               ovf;
   logic               unused_adr_lsbs;

   assign unused_adr_lsbs = ^wbs_adr_i[1:0];

   wb_port_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .clr   (fifo_clr),
      .din   (wbs_dat_i[FIFO_W-1:0]),
      .dout  (fifo_dout),
      .level (fifo_level),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Decode the request and derive the per-register strobes for this cycle.
   always_comb begin
      ofs       = {wbs_adr_i[7:2], 2'b00};
      hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
      accept    = wbs_cyc_i & wbs_stb_i & hit & ~ack;
      wr        = accept & wbs_we_i;
      rd        = accept & ~wbs_we_i;
      wr_out    = wr & (ofs == OFS_OUT);
      wr_cnt    = wr & (ofs == OFS_CNT);
      wr_ctrl   = wr & (ofs == OFS_CTRL) & wbs_sel_i[0];
      fifo_push = wr & (ofs == OFS_FIFO) & wbs_sel_i[0];
      fifo_pop  = rd & (ofs == OFS_FIFO);
      fifo_clr  = wr_ctrl & wbs_dat_i[CTRL_CLR_BIT];
      ovf_clr   = wr & (ofs == OFS_STATUS) & wbs_sel_i[1] & wbs_dat_i[ST_OVF_BIT];
      out_next  = {wbs_sel_i[1] ? wbs_dat_i[15:8] : out_reg[15:8],
                   wbs_sel_i[0] ? wbs_dat_i[7:0]  : out_reg[7:0]};
      cnt_next  = byte_merge(cnt, wbs_dat_i, wbs_sel_i);
   end

   // Read mux over pre-edge register values (CNT before its increment).
   always_comb begin
      status = {21'h0, ovf, fifo_full, fifo_empty, 1'b0, fifo_level};
      case (ofs)
         OFS_OUT:    rd_mux = {16'h0, out_reg};
         OFS_CNT:    rd_mux = cnt;
         OFS_CTRL:   rd_mux = {31'h0, ctrl_en};
         OFS_FIFO:   rd_mux = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
         OFS_STATUS: rd_mux = status;
         default:    rd_mux = 32'h0;
      endcase
   end

   // Single-cycle acknowledge with registered read data; the !ack term in
   // accept keeps ack from ever being high on two consecutive cycles.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack <= 1'b0;
         dat <= 32'h0;
      end else begin
         ack <= accept;
         dat <= rd ? rd_mux : 32'h0;
      end
   end

   // OUT register, byte lanes 0 and 1 only.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         out_reg <= 16'h0;
      end else if (wr_out) begin
         out_reg <= out_next;
      end
   end

   // Free-running counter; a bus write replaces that cycle's increment.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt <= 32'h0;
      end else if (wr_cnt) begin
         cnt <= cnt_next;
      end else if (ctrl_en) begin
         cnt <= cnt + 32'd1;
      end
   end

   // Counter enable; the FIFO clear bit is a pulse and is not stored.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ctrl_en <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en <= wbs_dat_i[CTRL_EN_BIT];
      end
   end

   // Sticky overflow flag; a dropped push beats a simultaneous clear.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ovf <= 1'b0;
      end else if (fifo_push & fifo_full) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

   assign wbs_ack_o = ack;
   assign wbs_dat_o = dat;
   assign user_out  = out_reg;
   assign user_oeb  = 16'h0000;

endmodule

// File: tb/tb_wb_port_responder.sv
// Self-checking bench for wb_port_responder: directed vector table, counter
// and bus-timing sequences, then random traffic against a queue-based model.
module tb_wb_port_responder;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          FD   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0;
   logic [31:0] wdat = 32'h0;
   logic        ack;
   logic [31:0] rdat;
   logic [15:0] user_out;
   logic [15:0] user_oeb;

   int n_total = 0;
   int n_pass  = 0;
   int edge_cnt = 0;

   wb_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(FD)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .user_out  (user_out),
      .user_oeb  (user_oeb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // ---------------- reference model ----------------
   logic [15:0] m_out = 16'h0;
   logic        m_en = 1'b0;
   logic [31:0] m_base = 32'h0;
   int          m_base_edge = 0;
   logic        m_ovf = 1'b0;
   logic [7:0]  m_q[$];

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   // Counter value just after edge k: base plus elapsed edges while enabled.
   function automatic logic [31:0] m_cnt_after(input int k);
      return m_base + (m_en ? 32'(k - m_base_edge) : 32'h0);
   endfunction

   function automatic logic [31:0] m_status();
      return {21'h0, m_ovf, (m_q.size() == FD), (m_q.size() == 0), 8'(m_q.size())};
   endfunction

   task automatic model_reset();
      m_out = 16'h0; m_en = 1'b0; m_base = 32'h0; m_base_edge = edge_cnt;
      m_ovf = 1'b0; m_q.delete();
   endtask

   // Apply an access that committed on edge k; r is the expected read data.
   task automatic model_commit(input logic w, input logic [7:0] o, input logic [3:0] s,
                               input logic [31:0] d, input int k, output logic [31:0] r);
      logic [31:0] v;
      r = 32'h0;
      case (o)
         8'h00: if (w) begin v = merge({16'h0, m_out}, d, s); m_out = v[15:0]; end
                else r = {16'h0, m_out};
         8'h04: if (w) begin m_base = merge(m_cnt_after(k - 1), d, s); m_base_edge = k; end
                else r = m_cnt_after(k - 1);
         8'h08: if (w) begin
                   if (s[0]) begin
                      v = m_cnt_after(k); m_base = v; m_base_edge = k; m_en = d[0];
                      if (d[1]) m_q.delete();
                   end
                end else r = {31'h0, m_en};
         8'h0C: if (w) begin
                   if (s[0]) begin
                      if (m_q.size() == FD) m_ovf = 1'b1;
                      else m_q.push_back(d[7:0]);
                   end
                end else if (m_q.size() != 0) r = {24'h0, m_q.pop_front()};
         8'h10: if (w) begin if (s[1] && d[10]) m_ovf = 1'b0; end
                else r = m_status();
         default: r = 32'h0;
      endcase
   endtask

   // ---------------- bus helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output bit acked, output int ce);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
      acked = 1'b0; rd = 32'h0; ce = 0;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(posedge clk); #1;
         if (ack) begin acked = 1'b1; rd = rdat; ce = edge_cnt; end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic bus_op(input logic w, input logic [7:0] o, input logic [3:0] s, input logic [31:0] d,
                         output logic [31:0] rd);
      bit acked; int ce; logic [31:0] exp;
      xfer(w, BASE | {24'h0, o}, s, d, rd, acked, ce);
      check($sformatf("ack_%s_%02h", w ? "wr" : "rd", o), {31'h0, acked}, 32'h1);
      if (acked) begin
         model_commit(w, o, s, d, ce, exp);
         if (!w) check($sformatf("rdata_%02h", o), rd, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        we;
      logic [7:0]  ofs;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp_rd;
      logic [15:0] exp_out;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic w, input logic [7:0] o, input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] er, input logic [15:0] eo);
      vec_t v;
      v.we = w; v.ofs = o; v.sel = s; v.dat = d; v.exp_rd = er; v.exp_out = eo;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd, mexp;
      bit acked, seen;
      int ce;
      logic [7:0] pat;
      logic [7:0] ofs_list [6];

      ofs_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", {31'h0, ack}, 32'h0);
      check("rst_dat", rdat, 32'h0);
      check("rst_out", {16'h0, user_out}, 32'h0);
      check("oeb", {16'h0, user_oeb}, 32'h0);
      rst = 1'b0;
      model_reset();

      add(1, 8'h00, 4'b0011, 32'h0000_AB60, 32'h0, 16'hAB60);
      add(1, 8'h00, 4'b0011, 32'h0000_AB61, 32'h0, 16'hAB61);
      add(0, 8'h00, 4'hF,    32'h0,         32'h0000_AB61, 16'hAB61);
      add(1, 8'h00, 4'b0001, 32'h0000_FF22, 32'h0, 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0100, 16'hAB22);
      for (int i = 0; i < 8; i++) add(1, 8'h0C, 4'b0001, 32'h11 + 32'(i), 32'h0, 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0208, 16'hAB22);
      add(1, 8'h0C, 4'b0001, 32'h99,        32'h0, 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0608, 16'hAB22);
      for (int i = 0; i < 8; i++) add(0, 8'h0C, 4'hF, 32'h0, 32'h11 + 32'(i), 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0500, 16'hAB22);
      add(0, 8'h0C, 4'hF,    32'h0,         32'h0, 16'hAB22);
      add(1, 8'h10, 4'hF,    32'h0000_0400, 32'h0, 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0100, 16'hAB22);
      add(1, 8'h0C, 4'b1110, 32'h77,        32'h0, 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0100, 16'hAB22);
      for (int i = 1; i <= 3; i++) add(1, 8'h0C, 4'b0001, 32'(i), 32'h0, 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0003, 16'hAB22);
      add(1, 8'h08, 4'hF,    32'h0000_0002, 32'h0, 16'hAB22);
      add(0, 8'h10, 4'hF,    32'h0,         32'h0000_0100, 16'hAB22);
      add(0, 8'h08, 4'hF,    32'h0,         32'h0, 16'hAB22);
      add(0, 8'h20, 4'hF,    32'h0,         32'h0, 16'hAB22);
      add(1, 8'h20, 4'hF,    32'hFFFF_FFFF, 32'h0, 16'hAB22);
      add(0, 8'h04, 4'hF,    32'h0,         32'h0, 16'hAB22);
      add(0, 8'h00, 4'hF,    32'h0,         32'h0000_AB22, 16'hAB22);

      for (int i = 0; i < tbl.size(); i++) begin
         xfer(tbl[i].we, BASE | {24'h0, tbl[i].ofs}, tbl[i].sel, tbl[i].dat, rd, acked, ce);
         check($sformatf("vec%0d_ack", i), {31'h0, acked}, 32'h1);
         if (acked) model_commit(tbl[i].we, tbl[i].ofs, tbl[i].sel, tbl[i].dat, ce, mexp);
         if (!tbl[i].we) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
         check($sformatf("vec%0d_out", i), {16'h0, user_out}, {16'h0, tbl[i].exp_out});
      end

      // Counter wrap: load, enable, idle three cycles, read.
      bus_op(1, 8'h04, 4'hF, 32'hFFFF_FFFE, rd);
      bus_op(1, 8'h08, 4'hF, 32'h0000_0001, rd);
      repeat (3) @(posedge clk);
      #1;
      bus_op(0, 8'h04, 4'hF, 32'h0, rd);
      check("cnt_wrap", rd, 32'h0000_0002);
      // Write during counting: written value held, next read sees one increment.
      bus_op(1, 8'h04, 4'hF, 32'h1234_5678, rd);
      bus_op(0, 8'h04, 4'hF, 32'h0, rd);
      check("cnt_load_running", rd, 32'h1234_5679);
      bus_op(1, 8'h08, 4'hF, 32'h0, rd);

      // Continuous strobe: ack alternates, each ack returns OUT.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
      pat = 8'h0;
      pat[7] = ack;
      for (int i = 6; i >= 0; i--) begin
         @(posedge clk); #1;
         pat[i] = ack;
         if (ack) check("burst_rd", rdat, {16'h0, m_out});
      end
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      check("ack_pattern", {24'h0, pat}, 32'h0000_0055);

      // Out-of-window write: no ack, no side effect.
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0100; sel = 4'hF; wdat = 32'hFFFF_FFFF;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ack) seen = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check("oow_noack", {31'h0, seen}, 32'h0);
      check("oow_out", {16'h0, user_out}, {16'h0, m_out});

      // Random traffic against the model.
      for (int n = 0; n < 120; n++) begin
         int unsigned pick;
         pick = $urandom_range(0, 9);
         case (pick)
            0:       bus_op(1, 8'h00, 4'($urandom_range(0, 15)), $urandom, rd);
            1:       bus_op(1, 8'h04, 4'hF, $urandom, rd);
            2:       bus_op(1, 8'h08, 4'hF, {30'h0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))}, rd);
            3, 4:    bus_op(1, 8'h0C, 4'($urandom_range(0, 15)), $urandom, rd);
            5, 6:    bus_op(0, 8'h0C, 4'hF, 32'h0, rd);
            7:       bus_op(1, 8'h10, 4'hF, $urandom, rd);
            8:       bus_op(0, ofs_list[$urandom_range(0, 5)], 4'hF, 32'h0, rd);
            default: bus_op(0, 8'h10, 4'hF, 32'h0, rd);
         endcase
         check("rand_out", {16'h0, user_out}, {16'h0, m_out});
      end

      // Reset while ack is high: ack and state clear asynchronously.
      bus_op(1, 8'h0C, 4'h1, 32'h5A, rd);
      bus_op(1, 8'h08, 4'hF, 32'h1, rd);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'h3; wdat = 32'h5555;
      @(posedge clk); #1;
      check("pre_rst_ack", {31'h0, ack}, 32'h1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_ack", {31'h0, ack}, 32'h0);
      check("mid_rst_out", {16'h0, user_out}, 32'h0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      #1 rst = 1'b0;
      model_reset();
      bus_op(0, 8'h00, 4'hF, 32'h0, rd);
      bus_op(0, 8'h04, 4'hF, 32'h0, rd);
      bus_op(0, 8'h08, 4'hF, 32'h0, rd);
      bus_op(0, 8'h0C, 4'hF, 32'h0, rd);
      bus_op(0, 8'h10, 4'hF, 32'h0, rd);
      check("post_rst_status", rd, 32'h0000_0100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
